// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: the serial line in, and the byte/strobe/status outputs.
// master = the receiver (drives outputs), slave = the byte-level consumer plus the line driver.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 framing_err;
    logic                 parity_err;

    modport master (
        input  rx,
        output rx_data, rx_valid, rx_busy, framing_err, parity_err
    );

    modport slave (
        output rx,
        input  rx_data, rx_valid, rx_busy, framing_err, parity_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first, idle high) with mid-bit sampling and one-cycle result strobes.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input logic       clk,
    input logic       reset,
    uart_rx_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_t;

`ifdef UART_RX_PARITY_EN
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    state_t               state_r;
    logic [1:0]           sync_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 busy_r;
    logic                 ferr_r;
    logic                 perr_r;
    logic                 stop_r;
    logic                 wait_high_r;
    logic                 rx_s;
    logic                 parity_ok_s;

    assign rx_s = sync_r[1];

`ifdef UART_RX_PARITY_EN
    logic par_r;
    assign parity_ok_s = ~parity_bad(shift_r, par_r);
`else
    assign parity_ok_s = 1'b1;
`endif

    // Synchroniser, bit-timing FSM and registered result strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r      <= 2'b11;
            state_r     <= IDLE;
            cnt_r       <= '0;
            idx_r       <= '0;
            shift_r     <= '0;
            data_r      <= '0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            ferr_r      <= 1'b0;
            perr_r      <= 1'b0;
            stop_r      <= 1'b0;
            wait_high_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            sync_r  <= {sync_r[0], bus.rx};
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            perr_r  <= 1'b0;
            cnt_r   <= cnt_r + 1'b1;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    idx_r <= '0;
                    // After a break the line must go high before a new start edge counts.
                    if (wait_high_r) begin
                        if (rx_s) begin
                            wait_high_r <= 1'b0;
                        end
                    end else if (!rx_s) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_r == HALF_CNT) begin
                        cnt_r <= '0;
                        if (!rx_s) begin
                            state_r <= DATA;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cnt_r == FULL_CNT) begin
                        cnt_r          <= '0;
                        shift_r[idx_r] <= rx_s;
                        idx_r          <= idx_r + 1'b1;
                        if (idx_r == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_r == FULL_CNT) begin
                        cnt_r   <= '0;
                        par_r   <= rx_s;
                        state_r <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt_r == FULL_CNT) begin
                        cnt_r   <= '0;
                        stop_r  <= rx_s;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    cnt_r       <= '0;
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    wait_high_r <= ~stop_r;
                    if (stop_r && parity_ok_s) begin
                        data_r  <= shift_r;
                        valid_r <= 1'b1;
                    end else begin
                        ferr_r <= ~stop_r;
                        perr_r <= ~parity_ok_s;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data     = data_r;
    assign bus.rx_valid    = valid_r;
    assign bus.rx_busy     = busy_r;
    assign bus.framing_err = ferr_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = perr_r;
`else
    assign bus.parity_err  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (CLKS_PER_BIT=16, DATA_BITS=8): frame timing, back-to-back,
// glitch, framing error, break, mid-frame reset and (when enabled) parity.
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Start fall seen by the DUT edge t0; D = t0+2; strobe at D+153 (+CPB with parity).
    localparam int LAT      = 2 + 153 + PAR_BITS * CPB;
    localparam int BUSY_LEN = 153 + PAR_BITS * CPB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         last_valid_cyc = 0;
    int         stretch = 0;
    int         busy_run = 0;
    int         last_run = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] got[$];

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            got.push_back(bus.rx_data);
        end
        if (bus.framing_err) ferr_cnt++;
        if (bus.parity_err) perr_cnt++;
        if ((bus.rx_valid && prev_valid) || (bus.framing_err && prev_ferr)) stretch++;
        prev_valid = bus.rx_valid;
        prev_ferr  = bus.framing_err;
        if (bus.rx_busy) begin
            busy_run++;
        end else begin
            if (busy_run != 0) last_run = busy_run;
            busy_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    // Drives one frame starting just after a falling edge; t0 is the first DUT edge seeing it.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int t0);
        t0 = cyc + 1;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        bus.rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        int t0;
        int t1;
        int v0;
        int f0;
        int p0;
        bus.rx = 1'b1;

        // Reset state
        settle(3);
        check("reset_data", 32'(bus.rx_data), 32'h00);
        check("reset_valid", 32'(bus.rx_valid), 32'h0);
        check("reset_busy", 32'(bus.rx_busy), 32'h0);
        check("reset_ferr", 32'(bus.framing_err), 32'h0);
        check("reset_perr", 32'(bus.parity_err), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        settle(4);

        // 0xA5 frame: latency, data, no error
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, t0);
        settle(4);
        check("a5_valid_count", 32'(valid_cnt - v0), 32'd1);
        check("a5_latency", 32'(last_valid_cyc - t0), 32'(LAT));
        check("a5_data", 32'(bus.rx_data), 32'hA5);
        check("a5_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("a5_busy_len", 32'(last_run), 32'(BUSY_LEN));

        // 0xFF frame: one strobe, busy spans the frame
        v0 = valid_cnt;
        send_frame(8'hFF, 1'b1, t0);
        settle(4);
        check("ff_valid_count", 32'(valid_cnt - v0), 32'd1);
        check("ff_data", 32'(bus.rx_data), 32'hFF);
        check("ff_busy_len", 32'(last_run), 32'(BUSY_LEN));
        check("ff_busy_idle", 32'(bus.rx_busy), 32'h0);

        // 0x00 then 0x3C with no idle gap
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'h3C, 1'b1, t1);
        settle(4);
        check("b2b_valid_count", 32'(valid_cnt - v0), 32'd2);
        check("b2b_first", 32'(got[got.size() - 2]), 32'h00);
        check("b2b_second", 32'(got[got.size() - 1]), 32'h3C);
        check("b2b_latency", 32'(last_valid_cyc - t1), 32'(LAT));
        check("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 4-cycle glitch: start rejected at mid-bit
        v0 = valid_cnt; f0 = ferr_cnt;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        settle(40);
        check("glitch_busy_len", 32'(last_run), 32'd8);
        check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 0x55 with stop bit low
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, t0);
        bus.rx = 1'b1;
        settle(20);
        check("ferr_count", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_valid", 32'(valid_cnt - v0), 32'd0);
        check("ferr_data_kept", 32'(bus.rx_data), 32'h3C);

        // Break: line low for 300 cycles, one framing error, then recovery
        v0 = valid_cnt; f0 = ferr_cnt;
        bus.rx = 1'b0;
        repeat (300) @(negedge clk);
        bus.rx = 1'b1;
        settle(20);
        check("break_ferr_once", 32'(ferr_cnt - f0), 32'd1);
        check("break_valid", 32'(valid_cnt - v0), 32'd0);
        send_frame(8'h5A, 1'b1, t0);
        settle(4);
        check("break_recover", 32'(bus.rx_data), 32'h5A);
        check("break_recover_count", 32'(valid_cnt - v0), 32'd1);

        // Reset pulsed mid-DATA, then 0x81
        v0 = valid_cnt; f0 = ferr_cnt;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        settle(2);
        check("mid_reset_busy", 32'(bus.rx_busy), 32'h0);
        check("mid_reset_data", 32'(bus.rx_data), 32'h00);
        check("mid_reset_valid", 32'(bus.rx_valid), 32'h0);
        check("mid_reset_ferr", 32'(bus.framing_err), 32'h0);
        reset = 1'b0;
        settle(200);
        check("mid_reset_no_strobe", 32'((valid_cnt - v0) + (ferr_cnt - f0)), 32'd0);
        send_frame(8'h81, 1'b1, t0);
        settle(4);
        check("after_reset_data", 32'(bus.rx_data), 32'h81);
        check("after_reset_latency", 32'(last_valid_cyc - t0), 32'(LAT));

`ifdef UART_RX_PARITY_EN
        // 0x07: parity bit 0 is wrong, parity bit 1 is right
        v0 = valid_cnt; p0 = perr_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, t0);
        settle(4);
        check("par_bad_perr", 32'(perr_cnt - p0), 32'd1);
        check("par_bad_valid", 32'(valid_cnt - v0), 32'd0);
        check("par_bad_data_kept", 32'(bus.rx_data), 32'h81);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, t0);
        settle(4);
        check("par_good_valid", 32'(valid_cnt - v0), 32'd1);
        check("par_good_data", 32'(bus.rx_data), 32'h07);
`endif
        p0 = perr_cnt;

        check("strobe_stretch", 32'(stretch), 32'd0);
`ifndef UART_RX_PARITY_EN
        check("parity_err_count", 32'(p0), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
